// File: rtl/led_pkg.sv
// Shared types and constants for the LED request arbiter and related status logic.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int LED_W          = 4;
    localparam int TICK_DIV_50MHZ = 5_000_000;
    localparam int MAX_REQ        = 8;

    // Index of the (single) set bit of a one-hot vector up to MAX_REQ wide.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request strictly after `last`,
// wrapping modulo N_REQ, returned one-hot with a valid flag.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    logic [IDX_W-1:0] sel;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        sel   = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            sel = IDX_W'((32'(last) + off) % N_REQ);
            if (!valid && req[sel]) begin
                pick[sel] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_req_arbiter.sv
// Round-robin owner of the shared LED flasher: grants one status requester at a
// time for a tick-quantised display window, followed by a dark gap.
module led_req_arbiter
    import led_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TICK_DIV   = TICK_DIV_50MHZ,
    parameter int HOLD_TICKS = 10,
    parameter int MAX_TICKS  = 30,
    parameter int GAP_TICKS  = 2
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [LED_W*N_REQ-1:0] pattern,
    output logic [N_REQ-1:0]       grant,
    output logic                   flash_vaild,
    output logic [LED_W-1:0]       led_mask,
    output logic                   busy
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // hcnt must also reach GAP_TICKS when the gap is longer than the max hold
    localparam int HSAT   = (MAX_TICKS > GAP_TICKS) ? MAX_TICKS : GAP_TICKS;
    localparam int HCNT_W = (HSAT > 0) ? $clog2(HSAT + 1) : 1;

    state_t            state;
    logic [TCNT_W-1:0] tcnt;
    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] hcnt_inc;
    logic [IDX_W-1:0]  last;

    logic [N_REQ-1:0]  pick;
    logic              pick_valid;
    logic [LED_W-1:0]  pick_mask;

    logic tick;
    logic owner_req;
    logic other_req;
    logic hold_met;
    logic max_met;
    logic leave_show;
    logic leave_gap;

    function automatic logic [HCNT_W-1:0] sat_inc(input logic [HCNT_W-1:0] v);
        return (int'(v) >= HSAT) ? v : v + 1'b1;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_mask = pick_mask | LED_W'(pattern >> (LED_W * i));
        end
    end

    assign tick      = (tcnt == TCNT_W'(TICK_DIV - 1));
    assign hcnt_inc  = sat_inc(hcnt);
    assign owner_req = |(req & grant);
    assign other_req = |(req & ~grant);
    assign hold_met  = int'(hcnt_inc) >= HOLD_TICKS;
    assign max_met   = int'(hcnt_inc) >= MAX_TICKS;

    // Decisions use the tick being completed, so hcnt_inc is the post-tick count.
    assign leave_show = tick && hold_met && (!owner_req || (max_met && other_req));
    assign leave_gap  = (GAP_TICKS == 0) || (tick && int'(hcnt_inc) >= GAP_TICKS);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tcnt        <= '0;
            hcnt        <= '0;
            last        <= IDX_W'(N_REQ - 1);
            grant       <= '0;
            flash_vaild <= 1'b0;
            led_mask    <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    hcnt <= '0;
                    if (pick_valid) begin
                        state       <= SHOW;
                        grant       <= pick;
                        last        <= IDX_W'(onehot_to_idx(MAX_REQ'(pick)));
                        led_mask    <= pick_mask;
                        flash_vaild <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SHOW: begin
                    tcnt <= tick ? '0 : tcnt + 1'b1;
                    if (leave_show) begin
                        state       <= GAP;
                        hcnt        <= '0;
                        grant       <= '0;
                        led_mask    <= '0;
                        flash_vaild <= 1'b0;
                    end else if (tick) begin
                        hcnt <= hcnt_inc;
                    end
                end
                GAP: begin
                    tcnt <= tick ? '0 : tcnt + 1'b1;
                    if (leave_gap) begin
                        state <= IDLE;
                        tcnt  <= '0;
                        hcnt  <= '0;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        hcnt <= hcnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_req_arbiter.sv
// Directed bench for led_req_arbiter with a short tick (TICK_DIV=4, HOLD=2, MAX=4, GAP=1).
module tb_led_req_arbiter;

    localparam int N_REQ      = 4;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 2;
    localparam int MAX_TICKS  = 4;
    localparam int GAP_TICKS  = 1;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] pattern;
    logic [3:0]  grant;
    logic        flash_vaild;
    logic [3:0]  led_mask;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] obs;
    logic [9:0] exp_v;

    localparam logic [9:0] GAP_V  = 10'b0000_0_0000_1;
    localparam logic [9:0] IDLE_V = 10'b0000_0_0000_0;

    assign obs = {grant, flash_vaild, led_mask, busy};

    led_req_arbiter #(
        .N_REQ      (N_REQ),
        .TICK_DIV   (TICK_DIV),
        .HOLD_TICKS (HOLD_TICKS),
        .MAX_TICKS  (MAX_TICKS),
        .GAP_TICKS  (GAP_TICKS)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .req         (req),
        .pattern     (pattern),
        .grant       (grant),
        .flash_vaild (flash_vaild),
        .led_mask    (led_mask),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [9:0] show_v(input logic [3:0] g, input logic [3:0] m);
        return {g, 1'b1, m, 1'b1};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        req     = 4'b0001;
        pattern = 16'h842A;
        step(3);
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL reset_hold got %b want %b", obs, IDLE_V);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL reset_release got %b want %b", obs, IDLE_V);
        else n_pass++;
        step(1);
        exp_v = show_v(4'b0001, 4'b1010);
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_first_grant got %b want %b", obs, exp_v);
        else n_pass++;
        req = 4'b0000;
        step(12);
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL reset_settle got %b want %b", obs, IDLE_V);
        else n_pass++;
    endtask

    task automatic test_single_pulse;
        req = 4'b0001;
        for (int c = 1; c <= 13; c++) begin
            step(1);
            if (c <= 8)       exp_v = show_v(4'b0001, 4'hA);
            else if (c <= 12) exp_v = GAP_V;
            else              exp_v = IDLE_V;
            n_checks++;
            if (obs !== exp_v) $display("FAIL pulse c=%0d got %b want %b", c, obs, exp_v);
            else n_pass++;
            if (c == 1) req = 4'b0000;
        end
    endtask

    task automatic test_round_robin;
        int ph;
        int k;
        rst_n = 1'b0;
        req   = 4'b0000;
        step(1);
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int c = 1; c <= 100; c++) begin
            step(1);
            ph = (c - 1) % 21;
            k  = ((c - 1) / 21) % 4;
            if (ph < 16)      exp_v = show_v(4'(1 << k), 4'(pattern >> (4 * k)));
            else if (ph < 20) exp_v = GAP_V;
            else              exp_v = IDLE_V;
            n_checks++;
            if (obs !== exp_v) $display("FAIL rr c=%0d got %b want %b", c, obs, exp_v);
            else n_pass++;
        end
        req = 4'b0000;
        step(5);
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL rr_settle got %b want %b", obs, IDLE_V);
        else n_pass++;
    endtask

    task automatic test_lone_holder;
        req = 4'b0100;
        for (int c = 1; c <= 50; c++) begin
            step(1);
            if (c <= 44)      exp_v = show_v(4'b0100, 4'h4);
            else if (c <= 48) exp_v = GAP_V;
            else if (c == 49) exp_v = IDLE_V;
            else              exp_v = show_v(4'b0010, 4'h2);
            n_checks++;
            if (obs !== exp_v) $display("FAIL lone c=%0d got %b want %b", c, obs, exp_v);
            else n_pass++;
            if (c == 41) req = 4'b0110;
        end
        req = 4'b0000;
        step(12);
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL lone_settle got %b want %b", obs, IDLE_V);
        else n_pass++;
    endtask

    task automatic test_pattern_change;
        req = 4'b0001;
        for (int c = 1; c <= 14; c++) begin
            step(1);
            if (c <= 8)       exp_v = show_v(4'b0001, 4'hA);
            else if (c <= 12) exp_v = GAP_V;
            else if (c == 13) exp_v = IDLE_V;
            else              exp_v = show_v(4'b0001, 4'h5);
            n_checks++;
            if (obs !== exp_v) $display("FAIL pattern c=%0d got %b want %b", c, obs, exp_v);
            else n_pass++;
            if (c == 1)  req = 4'b0000;
            if (c == 2)  pattern = 16'h1235;
            if (c == 13) req = 4'b0001;
        end
        req = 4'b0000;
        step(12);
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL pattern_settle got %b want %b", obs, IDLE_V);
        else n_pass++;
        pattern = 16'h842A;
    endtask

    task automatic test_reset_mid_show;
        req = 4'b0100;
        step(1);
        exp_v = show_v(4'b0100, 4'h4);
        n_checks++;
        if (obs !== exp_v) $display("FAIL midrst_grant got %b want %b", obs, exp_v);
        else n_pass++;
        step(2);
        n_checks++;
        if (obs !== exp_v) $display("FAIL midrst_hold got %b want %b", obs, exp_v);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL midrst_async got %b want %b", obs, IDLE_V);
        else n_pass++;
        req = 4'b1000;
        step(2);
        rst_n = 1'b1;
        step(1);
        exp_v = show_v(4'b1000, 4'h8);
        n_checks++;
        if (obs !== exp_v) $display("FAIL midrst_wrap got %b want %b", obs, exp_v);
        else n_pass++;
        req = 4'b0000;
        step(12);
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL midrst_settle got %b want %b", obs, IDLE_V);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_round_robin();
        test_lone_holder();
        test_pattern_change();
        test_reset_mid_show();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
